// File: rtl/tone_meter.sv
// tone_meter: classifies a square-wave tone (1..TONES kHz in 1 kHz steps) by measuring the
// rising-edge-to-rising-edge period of an asynchronous input in system clocks and locking onto
// the nearest tone index after MATCH consecutive agreeing periods.
//
// Ports:
//   clk    in   system clock, rising edge
//   rb     in   asynchronous active-low reset
//   sig_in in   asynchronous tone input
//   idx    out  locked tone index (k-1 for k kHz), held when the lock is lost
//   valid  out  idx holds a currently locked tone
//   chg    out  one-clock pulse whenever idx or valid changes
//
// Build option: define TONE_METER_DEGLITCH_EN to insert a 4-clock stability filter after the
// synchroniser (removes pulses of 3 clocks or shorter, adds 4 clocks of edge latency).
module tone_meter #(
   parameter int unsigned CLK_KHZ = 50_000,
   parameter int unsigned TONES   = 20,
   parameter int unsigned MATCH   = 3
) (
   input  logic       clk,
   input  logic       rb,
   input  logic       sig_in,
   output logic [4:0] idx,
   output logic       valid,
   output logic       chg
);

   localparam int unsigned   CntW       = 17;
   localparam logic [16:0]   CntMax     = '1;
   // Longest in-range period is U_1 = 2*CLK_KHZ; one clock beyond that is silence.
   localparam logic [16:0]   TimeoutCnt = 17'(2 * CLK_KHZ + 1);
   localparam logic [2:0]    MatchCnt   = 3'(MATCH);

   typedef enum logic [0:0] {StUnarmed, StArmed} state_e;

   // Bin edges: a period P belongs to tone k when lo_bound(k) < P <= hi_bound(k).
   function automatic int unsigned lo_bound(input int unsigned k);
      return (2 * CLK_KHZ) / (2 * k + 1);
   endfunction

   function automatic int unsigned hi_bound(input int unsigned k);
      return (2 * CLK_KHZ) / (2 * k - 1);
   endfunction

   // ---------------------------------------------------------------- input path
   logic sync1_q, sync2_q, lvl, prev_q, edge_q;

   always_ff @(posedge clk or negedge rb) begin
      if (!rb) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= sig_in;
         sync2_q <= sync1_q;
      end
   end

`ifdef TONE_METER_DEGLITCH_EN
   logic       filt_q;
   logic [1:0] stab_q;

   // Follow the synchronised level only once it has differed for 4 consecutive clocks.
   always_ff @(posedge clk or negedge rb) begin
      if (!rb) begin
         filt_q <= 1'b0;
         stab_q <= 2'd0;
      end else if (sync2_q == filt_q) begin
         stab_q <= 2'd0;
      end else if (stab_q == 2'd3) begin
         filt_q <= sync2_q;
         stab_q <= 2'd0;
      end else begin
         stab_q <= stab_q + 2'd1;
      end
   end

   assign lvl = filt_q;
`else
   assign lvl = sync2_q;
`endif

   logic [CntW-1:0] cnt_q;

   // cnt_q equals the number of clocks since the last recognised edge, so it is the period
   // whenever edge_q is high.
   always_ff @(posedge clk or negedge rb) begin
      if (!rb) begin
         prev_q <= 1'b0;
         edge_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         prev_q <= lvl;
         edge_q <= lvl & ~prev_q;
         if (edge_q) begin
            cnt_q <= 17'd1;
         end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + 17'd1;
         end
      end
   end

   // ---------------------------------------------------------------- classifier
   logic [31:0] per;
   logic [4:0]  cls;
   logic        cls_ok;

   assign per = 32'(cnt_q);

   always_comb begin
      cls    = '0;
      cls_ok = 1'b0;
      for (int unsigned k = 1; k <= TONES; k++) begin
         if (per > lo_bound(k) && per <= hi_bound(k)) begin
            cls    = 5'(k - 1);
            cls_ok = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------- lock FSM
   state_e     state_q, state_d;
   logic [4:0] cand_q, cand_d, idx_q, idx_d;
   logic [2:0] mcnt_q, mcnt_d;
   logic       valid_q, valid_d, chg_q, chg_d;
   logic       timeout;

   always_ff @(posedge clk or negedge rb) begin
      if (!rb) begin
         state_q <= StUnarmed;
         cand_q  <= '0;
         mcnt_q  <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         chg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         mcnt_q  <= mcnt_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         chg_q   <= chg_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      mcnt_d  = mcnt_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      chg_d   = 1'b0;
      timeout = (state_q == StArmed) && (cnt_q >= TimeoutCnt);

      if (timeout) begin
         state_d = StUnarmed;
         mcnt_d  = '0;
         if (valid_q) begin
            valid_d = 1'b0;
            chg_d   = 1'b1;
         end
      end

      if (edge_q) begin
         // Looking at state_d lets an edge coinciding with a timeout re-arm the meter.
         if (state_d == StUnarmed) begin
            state_d = StArmed;
         end else if (!cls_ok) begin
            mcnt_d = '0;
            cand_d = '0;
            if (valid_q) begin
               valid_d = 1'b0;
               chg_d   = 1'b1;
            end
         end else begin
            if (cls == cand_q) begin
               if (mcnt_q < MatchCnt) begin
                  mcnt_d = mcnt_q + 3'd1;
               end
            end else begin
               cand_d = cls;
               mcnt_d = 3'd1;
            end
            if (mcnt_d == MatchCnt && (cand_d != idx_q || !valid_q)) begin
               idx_d   = cand_d;
               valid_d = 1'b1;
               chg_d   = 1'b1;
            end
         end
      end
   end

   assign idx   = idx_q;
   assign valid = valid_q;
   assign chg   = chg_q;

endmodule

// File: tb/tb_tone_meter.sv
// Bench for tone_meter, run with a 1 MHz "system clock" (CLK_KHZ = 1000) so that every
// scenario fits a short simulation: U_1 = 2000, L_20 = 48, tone k has period 1000/k clocks.
`timescale 1ns/1ps
module tb_tone_meter;

   localparam int unsigned CK    = 1000;
   localparam int unsigned TONES = 20;
   localparam int unsigned MATCH = 3;
   localparam int unsigned U1    = 2 * CK;
`ifdef TONE_METER_DEGLITCH_EN
   localparam int LAT = 8;   // sig_in rise to registered classification
`else
   localparam int LAT = 4;
`endif

   logic       clk = 1'b0;
   logic       rb = 1'b0;
   logic       sig_in = 1'b0;
   logic [4:0] idx;
   logic       valid;
   logic       chg;

   tone_meter #(
      .CLK_KHZ(CK),
      .TONES  (TONES),
      .MATCH  (MATCH)
   ) dut (
      .clk   (clk),
      .rb    (rb),
      .sig_in(sig_in),
      .idx   (idx),
      .valid (valid),
      .chg   (chg)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int chg_seen = 0;
   always @(negedge clk) if (chg === 1'b1) chg_seen++;

   int n_chk = 0;
   int n_pass = 0;

   // Reference model: per-edge bookkeeping from the tone rules.
   bit          m_armed = 0;
   int          m_cand = 0;
   int          m_run = 0;
   int          m_idx = 0;
   bit          m_valid = 0;
   int          m_chg = 0;
   int unsigned m_last = 0;

   // Nearest tone: k with (2k-1)*P <= 2*CK < (2k+1)*P, i.e. round(CK/P) with exact halves.
   function automatic int nearest(input int unsigned p);
      int k;
      k = int'((2 * CK + p) / (2 * p));
      return (k >= 1 && k <= int'(TONES)) ? k - 1 : -1;
   endfunction

   task automatic model_drop();
      if (m_valid) begin
         m_valid = 0;
         m_chg++;
      end
   endtask

   task automatic model_timeout();
      m_armed = 0;
      m_run   = 0;
      model_drop();
   endtask

   task automatic model_reset();
      m_armed = 0;
      m_cand  = 0;
      m_run   = 0;
      m_idx   = 0;
      m_valid = 0;
   endtask

   task automatic model_edge(input int unsigned t);
      int unsigned p;
      int          k;
      p      = t - m_last;
      m_last = t;
      if (m_armed && p > U1) model_timeout();
      if (!m_armed) begin
         m_armed = 1;
         return;
      end
      k = nearest(p);
      if (k < 0) begin
         m_run  = 0;
         m_cand = 0;
         model_drop();
         return;
      end
      if (k == m_cand && m_run > 0) begin
         if (m_run < int'(MATCH)) m_run++;
      end else begin
         m_cand = k;
         m_run  = 1;
      end
      if (m_run == int'(MATCH) && (!m_valid || m_idx != m_cand)) begin
         m_idx   = m_cand;
         m_valid = 1;
         m_chg++;
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic check_state(input string tag);
      chk({tag, " idx"}, 32'(idx), 32'(m_idx));
      chk({tag, " valid"}, 32'(valid), 32'(m_valid));
      chk({tag, " chg count"}, 32'(chg_seen), 32'(m_chg));
   endtask

   // One square-wave period of length p starting with a rising edge now.
   task automatic period(input int p, input string tag);
      sig_in = 1'b1;
      model_edge(cyc);
      tick(LAT);
      #1;
      check_state(tag);
      tick(p / 2 - LAT);
      sig_in = 1'b0;
      tick(p - p / 2);
   endtask

   // Period with a 2-clock high glitch in the middle of the low phase.
   task automatic glitch_period(input int p);
      int hi, g;
      hi = p / 2;
      g  = hi + (p - hi) / 2;
      sig_in = 1'b1;
      model_edge(cyc);
      tick(LAT);
      #1;
      check_state("glitch main");
      tick(hi - LAT);
      sig_in = 1'b0;
      tick(g - hi);
      sig_in = 1'b1;
`ifndef TONE_METER_DEGLITCH_EN
      model_edge(cyc);
`endif
      tick(2);
      sig_in = 1'b0;
      tick(LAT - 2);
      #1;
      check_state("glitch pulse");
      tick(p - g - LAT);
   endtask

   initial begin
      int c0, p, reps;

      // Power-on reset
      tick(3);
      rb = 1'b1;
      tick(2);
      #1;
      chk("reset idx", 32'(idx), 0);
      chk("reset valid", 32'(valid), 0);
      chk("reset chg", 32'(chg), 0);

      // Lock at 5 kHz, then reset in the middle of a period and stay silent for 2*U_1
      for (int i = 0; i < 4; i++) period(200, "pre-reset");
      sig_in = 1'b1;
      tick(50);
      rb     = 1'b0;
      sig_in = 1'b0;
      model_reset();
      tick(3);
      rb = 1'b1;
      c0 = chg_seen;
      tick(2 * U1);
      #1;
      chk("post-reset idx", 32'(idx), 0);
      chk("post-reset valid", 32'(valid), 0);
      chk("post-reset chg pulses", 32'(chg_seen - c0), 0);

      // 5 kHz from unarmed: lock on the 4th edge with exactly one chg
      c0 = chg_seen;
      for (int i = 0; i < 3; i++) period(200, "5k");
      chk("5k valid before 4th edge", 32'(valid), 0);
      period(200, "5k");
      chk("5k idx", 32'(idx), 4);
      chk("5k valid", 32'(valid), 1);
      chk("5k chg pulses", 32'(chg_seen - c0), 1);

      // Switch to 20 kHz
      c0 = chg_seen;
      for (int i = 0; i < 4; i++) period(50, "20k");
      chk("20k idx", 32'(idx), 19);
      chk("20k valid", 32'(valid), 1);
      chk("20k chg at most two", 32'(chg_seen - c0 <= 2), 1);

      // Lower boundary: 49 stays at tone 20, 48 is out of range, 2000 is tone 1
      for (int i = 0; i < 4; i++) period(49, "p49");
      chk("p49 idx", 32'(idx), 19);
      chk("p49 valid", 32'(valid), 1);
      c0 = chg_seen;
      period(48, "p48");
      period(2000, "p48 seen");
      chk("p48 valid", 32'(valid), 0);
      chk("p48 idx held", 32'(idx), 19);
      chk("p48 chg pulses", 32'(chg_seen - c0), 1);
      for (int i = 0; i < 3; i++) period(2000, "p2000");
      chk("p2000 idx", 32'(idx), 0);
      chk("p2000 valid", 32'(valid), 1);

      // 1 kHz then silence: unlock exactly U_1+1 clocks after the classification point
      for (int i = 0; i < 3; i++) period(1000, "1k");
      c0 = chg_seen;
      tick(LAT + int'(U1) - 1000);
      #1;
      chk("timeout not yet", 32'(valid), 1);
      tick(1);
      #1;
      model_timeout();
      chk("timeout valid", 32'(valid), 0);
      chk("timeout idx held", 32'(idx), 0);
      chk("timeout chg pulses", 32'(chg_seen - c0), 1);
      tick(500);
      for (int i = 0; i < 4; i++) period(1000, "relock");
      chk("relock valid", 32'(valid), 1);
      chk("relock idx", 32'(idx), 0);

      // 3 kHz with mid-low glitches
      for (int i = 0; i < 6; i++) glitch_period(333);
`ifdef TONE_METER_DEGLITCH_EN
      chk("glitch idx", 32'(idx), 2);
      chk("glitch valid", 32'(valid), 1);
`else
      chk("glitch no lock at 2", 32'(valid === 1'b1 && idx === 5'd2), 0);
`endif

      // Random periods (in range, out of range, and exactly U_1+1 which coincides with timeout)
      for (int r = 0; r < 14; r++) begin
         p = int'($urandom_range(40, 420));
         if ($urandom_range(0, 6) == 0) p = 2001;
         reps = int'($urandom_range(1, 5));
         for (int j = 0; j < reps; j++) period(p, "random");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
